// File: rtl/traitement_audio_axil_regs.sv
// traitement_audio_axil_regs
// AXI4-Lite responder register bank for the traitement_audio IP.
//   0x00 CTRL, 0x04 GAIN, 0x08 SAMPLE_CFG, 0x0C SCRATCH : read/write, driven on *_o
//   0x10 STATUS                                        : read-only, sampled from status_i
//   0x14-0x1C                                          : unmapped
// AW and W are accepted independently (any order, same cycle allowed). The write commits on
// the edge after both are latched, and BVALID rises on that same edge. There is one
// outstanding write and one outstanding read. Read data is registered on the AR handshake edge.
// Optional build macro TRAITEMENT_AUDIO_SLVERR_EN: when it is defined, unmapped accesses
// answer SLVERR. When it is not defined, they answer OKAY. In both builds unmapped reads
// return zero and unmapped writes are dropped.
// Ports:
//   S_AXI_ACLK / S_AXI_ARESETN         clock, asynchronous active-low reset
//   S_AXI_AW* / S_AXI_W* / S_AXI_B*    write address, data and response channels
//   S_AXI_AR* / S_AXI_R*               read address and data channels
//   ctrl_o, gain_o, sample_cfg_o, scratch_o  control word outputs (flop outputs)
//   status_i                            status word, returned on reads of 0x10

module traitement_audio_axil_regs #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 5
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     ctrl_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     gain_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     sample_cfg_o,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     scratch_o,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     status_i
);

    localparam int unsigned DW     = C_S_AXI_DATA_WIDTH;
    localparam int unsigned SW     = C_S_AXI_DATA_WIDTH / 8;
    localparam int unsigned WordW  = C_S_AXI_ADDR_WIDTH - 2;

    localparam logic [WordW-1:0] IdxCtrl      = WordW'(0);
    localparam logic [WordW-1:0] IdxGain      = WordW'(1);
    localparam logic [WordW-1:0] IdxSampleCfg = WordW'(2);
    localparam logic [WordW-1:0] IdxScratch   = WordW'(3);
    localparam logic [WordW-1:0] IdxStatus    = WordW'(4);

    localparam logic [1:0] RespOkay = 2'b00;
`ifdef TRAITEMENT_AUDIO_SLVERR_EN
    localparam logic [1:0] RespUnmapped = 2'b10;
`else
    localparam logic [1:0] RespUnmapped = 2'b00;
`endif

    // Protection bits and byte offsets carry no meaning for this block.
    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    // Keeps every READY low until the first edge after reset release.
    logic init_q;

    logic             aw_latched_q;
    logic [WordW-1:0] aw_word_q;
    logic             w_latched_q;
    logic [DW-1:0]    w_data_q;
    logic [SW-1:0]    w_strb_q;

    logic             bvalid_q;
    logic [1:0]       bresp_q;
    logic             rvalid_q;
    logic [DW-1:0]    rdata_q;
    logic [1:0]       rresp_q;

    logic [DW-1:0]    ctrl_q, gain_q, sample_cfg_q, scratch_q;

    logic             aw_hs, w_hs, ar_hs, commit;
    logic [WordW-1:0] ar_word;
    logic [DW-1:0]    rd_data_d;
    logic [1:0]       rd_resp_d;
    logic [1:0]       wr_resp_d;

    assign S_AXI_AWREADY = init_q & ~aw_latched_q & ~bvalid_q;
    assign S_AXI_WREADY  = init_q & ~w_latched_q & ~bvalid_q;
    assign S_AXI_ARREADY = init_q & ~rvalid_q;

    assign aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs   = S_AXI_WVALID & S_AXI_WREADY;
    assign ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
    assign commit = aw_latched_q & w_latched_q;

    assign ar_word = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];

    // Byte-lane merge of new write data into the current register value.
    function automatic logic [DW-1:0] merge_strb(input logic [DW-1:0] old_val,
                                                 input logic [DW-1:0] new_val,
                                                 input logic [SW-1:0] strb);
        logic [DW-1:0] res;
        res = old_val;
        for (int b = 0; b < SW; b++) begin
            if (strb[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
        end
        return res;
    endfunction

    // Read mux uses the current register values, so a read that coincides with
    // a commit of the same register returns the pre-write value.
    always_comb begin
        rd_data_d = '0;
        rd_resp_d = RespOkay;
        unique case (ar_word)
            IdxCtrl:      rd_data_d = ctrl_q;
            IdxGain:      rd_data_d = gain_q;
            IdxSampleCfg: rd_data_d = sample_cfg_q;
            IdxScratch:   rd_data_d = scratch_q;
            IdxStatus:    rd_data_d = status_i;
            default:      rd_resp_d = RespUnmapped;
        endcase
    end

    always_comb begin
        wr_resp_d = RespOkay;
        if (aw_word_q > IdxStatus) wr_resp_d = RespUnmapped;
    end

    // Write address/data latches and write response.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            init_q       <= 1'b0;
            aw_latched_q <= 1'b0;
            aw_word_q    <= '0;
            w_latched_q  <= 1'b0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            bvalid_q     <= 1'b0;
            bresp_q      <= RespOkay;
        end else begin
            init_q <= 1'b1;
            if (aw_hs) begin
                aw_latched_q <= 1'b1;
                aw_word_q    <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
            end
            if (w_hs) begin
                w_latched_q <= 1'b1;
                w_data_q    <= S_AXI_WDATA;
                w_strb_q    <= S_AXI_WSTRB;
            end
            if (commit) begin
                aw_latched_q <= 1'b0;
                w_latched_q  <= 1'b0;
                bvalid_q     <= 1'b1;
                bresp_q      <= wr_resp_d;
            end else if (bvalid_q && S_AXI_BREADY) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // Control registers.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            ctrl_q       <= '0;
            gain_q       <= '0;
            sample_cfg_q <= '0;
            scratch_q    <= '0;
        end else if (commit) begin
            unique case (aw_word_q)
                IdxCtrl:      ctrl_q       <= merge_strb(ctrl_q, w_data_q, w_strb_q);
                IdxGain:      gain_q       <= merge_strb(gain_q, w_data_q, w_strb_q);
                IdxSampleCfg: sample_cfg_q <= merge_strb(sample_cfg_q, w_data_q, w_strb_q);
                IdxScratch:   scratch_q    <= merge_strb(scratch_q, w_data_q, w_strb_q);
                default:      ; // STATUS and unmapped slots ignore writes
            endcase
        end
    end

    // Read channel.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RespOkay;
        end else begin
            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_data_d;
                rresp_q  <= rd_resp_d;
            end else if (rvalid_q && S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign S_AXI_BVALID = bvalid_q;
    assign S_AXI_BRESP  = bresp_q;
    assign S_AXI_RVALID = rvalid_q;
    assign S_AXI_RDATA  = rdata_q;
    assign S_AXI_RRESP  = rresp_q;

    assign ctrl_o       = ctrl_q;
    assign gain_o       = gain_q;
    assign sample_cfg_o = sample_cfg_q;
    assign scratch_o    = scratch_q;

endmodule
